// File: rtl/branch_predictor_if.sv
// Pipeline-facing signals of the branch direction predictor: ID query, EX resolve, perf counters.
// The pipeline (master) drives the stage controls and outcome; the predictor (slave) answers.
interface branch_predictor_if;
  logic        branchD;
  logic [31:0] pcD;
  logic        pred_takenD;
  logic        stallE;
  logic        flushE;
  logic        actual_takenE;
  logic        pred_takenE;
  logic        mispredictE;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  modport master (
    output branchD, pcD, stallE, flushE, actual_takenE,
    input  pred_takenD, pred_takenE, mispredictE, branch_cnt, mispred_cnt
  );

  modport slave (
    input  branchD, pcD, stallE, flushE, actual_takenE,
    output pred_takenD, pred_takenE, mispredictE, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// 2-bit saturating-counter BHT: combinational ID prediction, one-cycle D->E carry, update as the branch leaves EX.
// No backpressure of its own; stallE holds the carried prediction and defers the table update.
module branch_predictor #(
  parameter int         IDX_W      = 6,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);
  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       bht_q [DEPTH];
  logic [1:0]       bht_d [DEPTH];
  logic             valid_e_q, valid_e_d;
  logic [IDX_W-1:0] idx_e_q, idx_e_d;
  logic             pred_e_q, pred_e_d;
  logic [31:0]      branch_cnt_q, branch_cnt_d;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;
  logic [IDX_W-1:0] idx_d;
  logic             upd;
  logic             unused_pc;

  // Word-aligned PC; upper bits alias onto the same entry by design.
  assign idx_d     = bp.pcD[IDX_W+1:2];
  assign unused_pc = ^{bp.pcD[31:IDX_W+2], bp.pcD[1:0]};

  assign bp.pred_takenD = bp.branchD & bht_q[idx_d][1];
  assign bp.pred_takenE = pred_e_q & valid_e_q;
  assign bp.mispredictE = valid_e_q & (pred_e_q ^ bp.actual_takenE);
  assign bp.branch_cnt  = branch_cnt_q;
  assign bp.mispred_cnt = mispred_cnt_q;

  // A stalled branch is still in EX next cycle, so it trains exactly once on its way out.
  assign upd = valid_e_q & ~bp.stallE;

  always_comb begin
    valid_e_d = valid_e_q;
    idx_e_d   = idx_e_q;
    pred_e_d  = pred_e_q;
    if (bp.flushE) begin
      valid_e_d = 1'b0;
      idx_e_d   = '0;
      pred_e_d  = 1'b0;
    end else if (!bp.stallE) begin
      valid_e_d = bp.branchD;
      idx_e_d   = idx_d;
      pred_e_d  = bp.pred_takenD;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (upd) begin
      if (bp.actual_takenE) begin
        if (bht_q[idx_e_q] != 2'b11) bht_d[idx_e_q] = bht_q[idx_e_q] + 2'b01;
      end else begin
        if (bht_q[idx_e_q] != 2'b00) bht_d[idx_e_q] = bht_q[idx_e_q] - 2'b01;
      end
    end
  end

  always_comb begin
    branch_cnt_d  = branch_cnt_q + 32'(upd);
    mispred_cnt_d = mispred_cnt_q + 32'(upd & bp.mispredictE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht_q[i] <= INIT_STATE;
      valid_e_q     <= 1'b0;
      idx_e_q       <= '0;
      pred_e_q      <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      bht_q         <= bht_d;
      valid_e_q     <= valid_e_d;
      idx_e_q       <= idx_e_d;
      pred_e_q      <= pred_e_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: reference counter table plus a queue of expected EX results per issued branch.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_if bp_if ();

  branch_predictor #(.IDX_W(6), .INIT_STATE(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bp  (bp_if)
  );

  typedef struct packed {
    logic pred;
    logic mis;
  } exp_t;

  exp_t        sb[$];
  logic [1:0]  m_bht [64];
  logic [31:0] m_branch;
  logic [31:0] m_mis;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [1:0] sat_next(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? 2'b11 : c + 2'b01;
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    m_branch = 0;
    m_mis    = 0;
    sb.delete();
  endtask

  // Issue one branch in ID, resolve it in EX the next cycle, then check counters.
  task automatic issue_resolve(input logic [31:0] pc, input logic act);
    exp_t       e;
    logic [5:0] ix;
    ix = pc[7:2];
    bp_if.branchD       = 1'b1;
    bp_if.pcD           = pc;
    bp_if.stallE        = 1'b0;
    bp_if.flushE        = 1'b0;
    bp_if.actual_takenE = 1'bx;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== m_bht[ix][1]) begin
      n_err++;
      $display("FAIL pred_takenD pc=%h got %b want %b", pc, bp_if.pred_takenD, m_bht[ix][1]);
    end
    n_vec++;
    if (bp_if.mispredictE !== 1'b0) begin
      n_err++;
      $display("FAIL idle_mispredictE pc=%h got %b want 0", pc, bp_if.mispredictE);
    end
    e.pred = m_bht[ix][1];
    e.mis  = m_bht[ix][1] ^ act;
    sb.push_back(e);
    tick();
    bp_if.branchD       = 1'b0;
    bp_if.pcD           = $urandom;
    bp_if.actual_takenE = act;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== 1'b0) begin
      n_err++;
      $display("FAIL pred_takenD_nobranch got %b want 0", bp_if.pred_takenD);
    end
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty got 0 entries want 1");
    end else begin
      e = sb.pop_front();
      n_vec++;
      if (bp_if.pred_takenE !== e.pred) begin
        n_err++;
        $display("FAIL pred_takenE pc=%h got %b want %b", pc, bp_if.pred_takenE, e.pred);
      end
      n_vec++;
      if (bp_if.mispredictE !== e.mis) begin
        n_err++;
        $display("FAIL mispredictE pc=%h got %b want %b", pc, bp_if.mispredictE, e.mis);
      end
    end
    tick();
    m_branch++;
    if (e.mis) m_mis++;
    m_bht[ix] = sat_next(m_bht[ix], act);
    bp_if.actual_takenE = 1'bx;
    n_vec++;
    if (bp_if.branch_cnt !== m_branch) begin
      n_err++;
      $display("FAIL branch_cnt got %0d want %0d", bp_if.branch_cnt, m_branch);
    end
    n_vec++;
    if (bp_if.mispred_cnt !== m_mis) begin
      n_err++;
      $display("FAIL mispred_cnt got %0d want %0d", bp_if.mispred_cnt, m_mis);
    end
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bp_if.branchD       = 1'b0;
    bp_if.pcD           = 32'h0;
    bp_if.stallE        = 1'b0;
    bp_if.flushE        = 1'b0;
    bp_if.actual_takenE = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h10;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pred_takenD got %b want 0", bp_if.pred_takenD);
    end
    n_vec++;
    if (bp_if.branch_cnt !== 32'd0 || bp_if.mispred_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", bp_if.branch_cnt, bp_if.mispred_cnt);
    end
    n_vec++;
    if (bp_if.pred_takenE !== 1'b0 || bp_if.mispredictE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ex_outputs got %b%b want 00", bp_if.pred_takenE, bp_if.mispredictE);
    end
    bp_if.branchD = 1'b0;
    tick();
  endtask

  task automatic test_predict();
    issue_resolve(32'h10, 1'b1);
    n_vec++;
    if (bp_if.mispred_cnt !== 32'd1) begin
      n_err++;
      $display("FAIL first_mispred_cnt got %0d want 1", bp_if.mispred_cnt);
    end
    issue_resolve(32'h10, 1'b1);
    n_vec++;
    if (bp_if.branch_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL second_branch_cnt got %0d want 2", bp_if.branch_cnt);
    end
  endtask

  task automatic test_saturation();
    repeat (4) issue_resolve(32'h20, 1'b1);
    issue_resolve(32'h20, 1'b0);
    issue_resolve(32'h20, 1'b1);
  endtask

  task automatic test_alias();
    issue_resolve(32'h0, 1'b1);
    issue_resolve(32'h0, 1'b1);
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h100;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== 1'b1) begin
      n_err++;
      $display("FAIL alias_pred_takenD got %b want 1", bp_if.pred_takenD);
    end
    bp_if.branchD = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    logic ex_pred;
    ex_pred             = m_bht[16][1];
    bp_if.branchD       = 1'b1;
    bp_if.pcD           = 32'h40;
    tick();
    bp_if.pcD           = 32'h44;
    bp_if.stallE        = 1'b1;
    bp_if.actual_takenE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (bp_if.mispredictE !== (ex_pred ^ 1'b1) || bp_if.pred_takenE !== ex_pred) begin
        n_err++;
        $display("FAIL stall_hold cycle=%0d got mis=%b pred=%b want mis=%b pred=%b",
                 i, bp_if.mispredictE, bp_if.pred_takenE, ex_pred ^ 1'b1, ex_pred);
      end
      tick();
      n_vec++;
      if (bp_if.branch_cnt !== m_branch) begin
        n_err++;
        $display("FAIL stall_branch_cnt cycle=%0d got %0d want %0d", i, bp_if.branch_cnt, m_branch);
      end
    end
    bp_if.stallE  = 1'b0;
    bp_if.branchD = 1'b0;
    tick();
    m_branch++;
    if (ex_pred ^ 1'b1) m_mis++;
    m_bht[16] = sat_next(m_bht[16], 1'b1);
    bp_if.actual_takenE = 1'bx;
    n_vec++;
    if (bp_if.branch_cnt !== m_branch || bp_if.mispred_cnt !== m_mis) begin
      n_err++;
      $display("FAIL stall_release_counts got %0d/%0d want %0d/%0d",
               bp_if.branch_cnt, bp_if.mispred_cnt, m_branch, m_mis);
    end
    issue_resolve(32'h40, 1'b0);
    issue_resolve(32'h40, 1'b1);
  endtask

  task automatic test_flush();
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h80;
    bp_if.flushE  = 1'b1;
    tick();
    bp_if.flushE        = 1'b0;
    bp_if.branchD       = 1'b0;
    bp_if.actual_takenE = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenE !== 1'b0 || bp_if.mispredictE !== 1'b0) begin
      n_err++;
      $display("FAIL flush_ex_outputs got %b%b want 00", bp_if.pred_takenE, bp_if.mispredictE);
    end
    tick();
    n_vec++;
    if (bp_if.branch_cnt !== m_branch || bp_if.mispred_cnt !== m_mis) begin
      n_err++;
      $display("FAIL flush_counts got %0d/%0d want %0d/%0d",
               bp_if.branch_cnt, bp_if.mispred_cnt, m_branch, m_mis);
    end
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h84;
    tick();
    bp_if.branchD = 1'b0;
    bp_if.flushE  = 1'b1;
    bp_if.stallE  = 1'b1;
    tick();
    bp_if.flushE = 1'b0;
    bp_if.stallE = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bp_if.mispredictE !== 1'b0) begin
      n_err++;
      $display("FAIL flush_over_stall got %b want 0", bp_if.mispredictE);
    end
    tick();
    bp_if.actual_takenE = 1'bx;
    n_vec++;
    if (bp_if.branch_cnt !== m_branch) begin
      n_err++;
      $display("FAIL flush_over_stall_cnt got %0d want %0d", bp_if.branch_cnt, m_branch);
    end
  endtask

  task automatic test_same_index();
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h14;
    tick();
    bp_if.actual_takenE = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== 1'b0 || bp_if.mispredictE !== 1'b1) begin
      n_err++;
      $display("FAIL same_idx_old got pred=%b mis=%b want pred=0 mis=1", bp_if.pred_takenD, bp_if.mispredictE);
    end
    tick();
    m_branch++;
    m_mis++;
    m_bht[5] = sat_next(m_bht[5], 1'b1);
    @(negedge clk);
    n_vec++;
    if (bp_if.pred_takenD !== 1'b1) begin
      n_err++;
      $display("FAIL same_idx_new got %b want 1", bp_if.pred_takenD);
    end
    bp_if.branchD = 1'b0;
    n_vec++;
    if (bp_if.mispredictE !== 1'b1) begin
      n_err++;
      $display("FAIL same_idx_second_mis got %b want 1", bp_if.mispredictE);
    end
    tick();
    m_branch++;
    m_mis++;
    m_bht[5] = sat_next(m_bht[5], 1'b1);
    bp_if.actual_takenE = 1'bx;
    n_vec++;
    if (bp_if.branch_cnt !== m_branch || bp_if.mispred_cnt !== m_mis) begin
      n_err++;
      $display("FAIL same_idx_counts got %0d/%0d want %0d/%0d",
               bp_if.branch_cnt, bp_if.mispred_cnt, m_branch, m_mis);
    end
  endtask

  task automatic test_reset_mid();
    issue_resolve(32'h30, 1'b1);
    issue_resolve(32'h30, 1'b1);
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h30;
    tick();
    rst                 = 1'b1;
    bp_if.branchD       = 1'b0;
    bp_if.actual_takenE = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_vec++;
    if (bp_if.mispredictE !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_mispredictE got %b want 0", bp_if.mispredictE);
    end
    n_vec++;
    if (bp_if.branch_cnt !== 32'd0 || bp_if.mispred_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_counters got %0d/%0d want 0/0", bp_if.branch_cnt, bp_if.mispred_cnt);
    end
    bp_if.branchD = 1'b1;
    bp_if.pcD     = 32'h30;
    #1;
    n_vec++;
    if (bp_if.pred_takenD !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_table got %b want 0", bp_if.pred_takenD);
    end
    bp_if.branchD       = 1'b0;
    bp_if.actual_takenE = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_predict();
    test_saturation();
    test_alias();
    test_stall();
    test_flush();
    test_same_index();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
